// File: rtl/chess_input_conditioner.sv
// Input front end for the chess timer: synchronizes and debounces raw player
// inputs, detects presses and hands accepted moves to the control FSM.
module chess_input_conditioner #(
  parameter int N_INPUTS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset,
  input  logic [N_INPUTS-1:0]                        i_raw,
  output logic [N_INPUTS-1:0]                        o_level,
  output logic [N_INPUTS-1:0]                        o_press,
  output logic                                       o_move_valid,
  output logic [((N_INPUTS > 1) ? $clog2(N_INPUTS) : 1)-1:0] o_move_id,
  input  logic                                       i_move_ack,
  output logic                                       o_conflict,
  output logic                                       o_overrun
);

  localparam int ID_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [N_INPUTS-1:0] RELEASED = ACTIVE_LOW ? {N_INPUTS{1'b1}} : {N_INPUTS{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_INPUTS-1:0] sync1;
  logic [N_INPUTS-1:0] sync2;
  logic [N_INPUTS-1:0] s;
  logic [CNT_W-1:0]    cnt [N_INPUTS];

  logic            cand_valid;
  logic [ID_W-1:0] cand_id;
  logic            multi;
  logic            pending;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
    end
  end

  assign s = ACTIVE_LOW ? ~sync2 : sync2;

  // Level only flips after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_level <= '0;
      o_press <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        o_press[i] <= 1'b0;
        if (s[i] == o_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          o_level[i] <= s[i];
          o_press[i] <= s[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lowest-index press wins; any additional simultaneous press is a conflict.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    multi      = 1'b0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (o_press[i]) begin
        if (cand_valid) begin
          multi = 1'b1;
        end
        cand_valid = 1'b1;
        cand_id    = ID_W'(i);
      end
    end
  end

  assign pending = o_move_valid & ~i_move_ack;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_move_valid <= 1'b0;
      o_move_id    <= '0;
      o_conflict   <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_conflict <= multi;
      o_overrun  <= 1'b0;
      if (cand_valid) begin
        if (pending) begin
          o_overrun <= 1'b1;
        end else begin
          o_move_valid <= 1'b1;
          o_move_id    <= cand_id;
        end
      end else if (i_move_ack) begin
        o_move_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chess_input_conditioner.sv
// Randomized bench for chess_input_conditioner: an active-high and an
// active-low instance share one behavioural model of the accepted moves.
module tb_chess_input_conditioner;

  localparam int N = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] raw;
  logic         ack;

  logic [N-1:0] hi_level, hi_press, lo_level, lo_press;
  logic         hi_valid, hi_conflict, hi_overrun, lo_valid, lo_conflict, lo_overrun;
  logic [0:0]   hi_id, lo_id;

  int total_checks = 0;
  int bad_checks   = 0;

  // Model state: raw samples two edges deep, then debounce and handshake.
  logic [N-1:0] m_d1, m_d2, m_level, m_press;
  int           m_run [N];
  logic         m_valid, m_id, m_conflict, m_overrun;

  int           hold_left [N];
  logic [N-1:0] cur;

  always #5 clk = ~clk;

  chess_input_conditioner #(.N_INPUTS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_hi (
    .i_clk(clk), .i_reset(reset), .i_raw(raw),
    .o_level(hi_level), .o_press(hi_press),
    .o_move_valid(hi_valid), .o_move_id(hi_id), .i_move_ack(ack),
    .o_conflict(hi_conflict), .o_overrun(hi_overrun)
  );

  chess_input_conditioner #(.N_INPUTS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_lo (
    .i_clk(clk), .i_reset(reset), .i_raw(~raw),
    .o_level(lo_level), .o_press(lo_press),
    .o_move_valid(lo_valid), .o_move_id(lo_id), .i_move_ack(ack),
    .o_conflict(lo_conflict), .o_overrun(lo_overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, observed, expected);
    end
  endtask

  // One clock edge of the reference: a change is accepted after D
  // consecutive post-synchronizer samples disagree with the current level.
  task automatic model_step(input logic [N-1:0] r, input logic a, input logic rst);
    logic [N-1:0] s_now;
    int           n_press;
    int           lowest;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0;
      m_valid = 1'b0; m_id = 1'b0; m_conflict = 1'b0; m_overrun = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      return;
    end
    n_press = 0;
    lowest  = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_press[i]) begin
        n_press++;
        lowest = i;
      end
    end
    m_conflict = (n_press > 1);
    m_overrun  = 1'b0;
    if (lowest >= 0) begin
      if (m_valid && !a) begin
        m_overrun = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_id    = lowest[0];
      end
    end else if (a) begin
      m_valid = 1'b0;
    end
    s_now = m_d2;
    m_d2  = m_d1;
    m_d1  = r;
    for (int i = 0; i < N; i++) begin
      m_press[i] = 1'b0;
      if (s_now[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_level[i] = s_now[i];
          m_press[i] = s_now[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic a, input logic rst);
    raw   = r;
    ack   = a;
    reset = rst;
    @(posedge clk);
    model_step(r, a, rst);
    #1;
    checkOutput("hi.level",    32'(hi_level),    32'(m_level));
    checkOutput("hi.press",    32'(hi_press),    32'(m_press));
    checkOutput("hi.valid",    32'(hi_valid),    32'(m_valid));
    checkOutput("hi.id",       32'(hi_id),       32'(m_id));
    checkOutput("hi.conflict", 32'(hi_conflict), 32'(m_conflict));
    checkOutput("hi.overrun",  32'(hi_overrun),  32'(m_overrun));
    checkOutput("lo.level",    32'(lo_level),    32'(m_level));
    checkOutput("lo.press",    32'(lo_press),    32'(m_press));
    checkOutput("lo.valid",    32'(lo_valid),    32'(m_valid));
    checkOutput("lo.id",       32'(lo_id),       32'(m_id));
    checkOutput("lo.conflict", 32'(lo_conflict), 32'(m_conflict));
    checkOutput("lo.overrun",  32'(lo_overrun),  32'(m_overrun));
  endtask

  initial begin
    raw   = '0;
    ack   = 1'b0;
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b11, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Reset in the middle of a debounce must not leave a pending press.
    for (int k = 0; k < 4; k++) applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Clean press on channel 1, then ack it.
    for (int k = 0; k < 10; k++) applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Bounce on channel 0 before settling.
    for (int k = 0; k < 4; k++) applyStimulus((k % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(2'b01, 1'b0, 1'b0);

    // Channel 1 pressed while move 0 is still pending: overrun.
    for (int k = 0; k < 10; k++) applyStimulus(2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(2'b00, 1'b1, 1'b0);

    // Simultaneous press on both channels.
    for (int k = 0; k < 12; k++) applyStimulus(2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Channel 1 press landing exactly in an ack cycle.
    for (int k = 0; k < 5; k++) applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(2'b10, 1'b0, 1'b0);

    cur = '0;
    for (int i = 0; i < N; i++) hold_left[i] = 1;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) begin
        hold_left[i]--;
        if (hold_left[i] <= 0) begin
          cur[i] = ~cur[i];
          hold_left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(5, 14));
        end
      end
      applyStimulus(cur, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/chess_input_conditioner.md
Name: chess_input_conditioner

Overview:
Input-side front end for the chess timer. Takes the raw, asynchronous player inputs (switches or push-buttons) and synchronizes and debounces them. It detects presses and presents each accepted "move" to the control FSM through a single-entry valid/ack handshake. It sits between the board pins and the FSM's button inputs, the counterpart of the display path on the output side.

Parameters:
N_INPUTS, 2, number of player input channels (channel index = player id)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be >= 1
ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed (KEY pins); 0 = reads 1 when pressed (SW pins)

Ports:
i_clk  input  1  system clock (50 MHz)
i_reset  input  1  synchronous, active-high reset
i_raw  input  N_INPUTS  raw asynchronous pin levels
o_level  output  N_INPUTS  debounced pressed level, 1 = pressed (polarity already normalized)
o_press  output  N_INPUTS  one-cycle pulse on debounced press edge
o_move_valid  output  1  a move is pending for the FSM
o_move_id  output  $clog2(N_INPUTS) (min 1)  channel that produced the pending move
i_move_ack  input  1  FSM consumes pending move; sampled only while o_move_valid=1
o_conflict  output  1  one-cycle pulse: two or more presses were accepted in the same cycle
o_overrun  output  1  one-cycle pulse: a press was dropped because a move was already pending

Behaviour:
- Reset (i_reset=1 at a clock edge): synchronizer flops load the released level; debounce counters = 0; o_level = 0; o_press = 0; o_move_valid = 0; o_move_id = 0; o_conflict = 0; o_overrun = 0. Reset mid-debounce or mid-handshake discards all state; no pulse is emitted on reset release.
- Per channel: a 2-FF synchronizer, then polarity normalization (invert if ACTIVE_LOW), producing s[i].
- Debounce per channel: counter width $clog2(DEBOUNCE_CYCLES+1).
  - When s[i] == o_level[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while s[i] still differs, o_level[i] <= s[i] and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Latency: a raw change held steady reaches o_level exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it.
- o_press[i] = 1 for exactly the cycle in which o_level[i] goes 0->1. Releases produce no pulse.
- Move handshake, evaluated each cycle:
  - Selection: when any o_press bit is set, the lowest-index pressed channel is the candidate. If more than one bit is set, o_conflict pulses and the others are dropped.
  - Pending = o_move_valid and not i_move_ack.
  - If a candidate exists and nothing is pending: o_move_valid <= 1, o_move_id <= candidate.
  - If a candidate exists while a move is pending: the press is dropped, o_overrun pulses, and o_move_id is unchanged.
  - If i_move_ack=1 with no candidate: o_move_valid <= 0.
  - If i_move_ack and a candidate occur in the same cycle: the new move is latched (valid stays 1, id updated) and there is no overrun.
  - o_move_id is stable for as long as o_move_valid=1 without ack.
  - i_move_ack while o_move_valid=0 is ignored.
- Conflict and overrun can pulse in the same cycle.
- All outputs are registered. There are no combinational paths from i_raw or i_move_ack to outputs.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, N_INPUTS=2.
- Reset then idle: i_raw=00 for 20 cycles -> all outputs 0; assert i_reset mid-debounce -> counters clear, no o_press after release.
- Clean press: i_raw[1] 0->1 held -> o_level[1]=1 and o_press=10 for one cycle exactly 6 edges after first sample; o_move_valid=1, o_move_id=1 the next cycle; hold until i_move_ack=1 -> valid=0 the following cycle.
- Bounce: i_raw[0] toggles 1,0,1,0 every 2 cycles then holds 1 -> a single o_press[0] pulse, 6 edges after the final rising edge; no extra pulses on release bounce.
- Simultaneous presses: both channels rise in the same cycle -> o_press=11, o_conflict pulses once, o_move_id=0.
- Overrun and ack race: with move 0 pending and no ack, press channel 1 -> o_overrun pulses, id stays 0. Repeat with i_move_ack=1 in the press cycle -> no overrun, valid stays 1, id=1.
- ACTIVE_LOW=1: i_raw idle 11, drive bit0 to 0 -> o_level[0]=1 and o_press[0] pulse; reset with i_raw=11 -> o_level=00.
